// File: rtl/bist_controller_pkg.sv
// Shared definitions for the BIST sequencer: FSM state encoding and the
// default fault-free signature used when a build does not override it.
package bist_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } bist_state_t;

    localparam logic [15:0] DEFAULT_GOLDEN_SIG = 16'h0000;

endpackage

// File: rtl/bist_controller_edge_det.sv
// Rising-edge detector for the tester's start level. The history register
// comes out of reset at 1 so a start line already high during reset is not
// mistaken for a fresh request.
module bist_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    // remember last cycle's level; reset to 1 to swallow a start held through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the LFSR, clears the MISR, resets the CUT, clocks a
// fixed number of patterns, drains the CUT pipeline into the MISR and then
// compares the signature against the golden value.
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int               N_PATTERNS = 16,
    parameter int               CNT_W      = 8,
    parameter int               CUT_LAT    = 1,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(DEFAULT_GOLDEN_SIG)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bist_start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             test_mode,
    output logic             lfsr_load,
    output logic             lfsr_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             cut_rst,
    output logic             bist_busy,
    output logic             bist_end,
    output logic             pass_fail
);

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);

    bist_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             start_rise;

    bist_edge_det u_edge_det (
        .clk   (CLK),
        .rst   (RST),
        .level (bist_start),
        .rise  (start_rise)
    );

    // state, shared pattern/drain counter and the latched verdict
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // next-state logic and Moore output decode; counter is reused by RUN and FLUSH
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        test_mode = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        cut_rst   = 1'b0;
        bist_busy = 1'b0;
        bist_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_INIT;
                    pass_d  = 1'b0;
                end
            end
            ST_INIT: begin
                lfsr_load = 1'b1;
                misr_clr  = 1'b1;
                cut_rst   = 1'b1;
                test_mode = 1'b1;
                bist_busy = 1'b1;
                cnt_d     = '0;
                pass_d    = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                test_mode = 1'b1;
                lfsr_en   = 1'b1;
                misr_en   = 1'b1;
                bist_busy = 1'b1;
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = (CUT_LAT > 0) ? ST_FLUSH : ST_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                test_mode = 1'b1;
                misr_en   = 1'b1;
                bist_busy = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMPARE: begin
                test_mode = 1'b1;
                bist_busy = 1'b1;
                pass_d    = (misr_sig == GOLDEN_SIG);
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                bist_end = 1'b1;
                if (start_rise) begin
                    pass_d  = 1'b0;
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign pass_fail = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller. A timeline model predicts outputs
// from the cycle offset since the accepted start edge.
module tb_bist_controller;

    localparam int          N_PAT    = 4;
    localparam int          LAT      = 1;
    localparam logic [15:0] GOLDEN   = 16'hA5C3;
    localparam int          LAST_OFF = N_PAT + LAT + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        bist_start = 1'b1;
    logic [15:0] misr_sig = 16'h0000;
    logic test_mode, lfsr_load, lfsr_en, misr_clr, misr_en, cut_rst;
    logic bist_busy, bist_end, pass_fail;
    logic [8:0] dut_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state: run in progress, offset into it, finished flag, verdict
    logic m_prev = 1'b1;
    logic m_active = 1'b0;
    logic m_done = 1'b0;
    logic m_pf = 1'b0;
    int   m_off = 0;

    bist_controller #(
        .N_PATTERNS (N_PAT),
        .CNT_W      (8),
        .CUT_LAT    (LAT),
        .SIG_W      (16),
        .GOLDEN_SIG (GOLDEN)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bist_start (bist_start),
        .misr_sig   (misr_sig),
        .test_mode  (test_mode),
        .lfsr_load  (lfsr_load),
        .lfsr_en    (lfsr_en),
        .misr_clr   (misr_clr),
        .misr_en    (misr_en),
        .cut_rst    (cut_rst),
        .bist_busy  (bist_busy),
        .bist_end   (bist_end),
        .pass_fail  (pass_fail)
    );

    assign dut_out = {test_mode, lfsr_load, lfsr_en, misr_clr, misr_en,
                      cut_rst, bist_busy, bist_end, pass_fail};

    always #50 CLK = ~CLK;

    // timeline model: offset 0 is setup, then patterns, drain, compare, done
    always @(posedge CLK) begin
        if (RST) begin
            m_prev   <= 1'b1;
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_pf     <= 1'b0;
            m_off    <= 0;
        end else begin
            m_prev <= bist_start;
            if (m_active) begin
                if (m_off == LAST_OFF) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_pf     <= (misr_sig == GOLDEN);
                end else begin
                    m_off <= m_off + 1;
                end
            end else if (bist_start && !m_prev) begin
                m_active <= 1'b1;
                m_off    <= 0;
                m_pf     <= 1'b0;
                m_done   <= 1'b0;
            end
        end
    end

    // expected {test_mode,lfsr_load,lfsr_en,misr_clr,misr_en,cut_rst,busy,end,pass_fail}
    function automatic logic [8:0] exp_out();
        logic [8:0] e;
        e = '0;
        if (m_active) begin
            e[8] = 1'b1;
            e[2] = 1'b1;
            if (m_off == 0) begin
                e[7] = 1'b1;
                e[5] = 1'b1;
                e[3] = 1'b1;
            end else if (m_off <= N_PAT) begin
                e[6] = 1'b1;
                e[4] = 1'b1;
            end else if (m_off <= N_PAT + LAT) begin
                e[4] = 1'b1;
            end
        end else if (m_done) begin
            e[1] = 1'b1;
            e[0] = m_pf;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bist_start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (dut_out !== 9'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d got %b expected %b", cyc, dut_out, 9'b0);
            end
        end
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (dut_out !== 9'b0) begin
                errors++;
                $display("[TB] FAIL reset_start_held cycle %0d got %b expected %b", cyc, dut_out, 9'b0);
            end
        end
    endtask

    task automatic test_run(input logic [15:0] sig, input logic want_pf);
        int lfsr_cnt = 0;
        int misr_cnt = 0;
        int pulse_cnt = 0;
        int end_at = -1;
        misr_sig = sig;
        bist_start = 1'b0;
        tick();
        bist_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                $display("[TB] FAIL run_outputs cycle %0d got %b expected %b", cyc, dut_out, exp_out());
            end
            if (lfsr_en) lfsr_cnt++;
            if (misr_en) misr_cnt++;
            if (lfsr_load && misr_clr && cut_rst) pulse_cnt++;
            if (bist_end && end_at < 0) end_at = c - 1;
        end
        checks += 5;
        if (lfsr_cnt != N_PAT) begin
            errors++;
            $display("[TB] FAIL run_lfsr_en_count got %0d expected %0d", lfsr_cnt, N_PAT);
        end
        if (misr_cnt != N_PAT + LAT) begin
            errors++;
            $display("[TB] FAIL run_misr_en_count got %0d expected %0d", misr_cnt, N_PAT + LAT);
        end
        if (pulse_cnt != 1) begin
            errors++;
            $display("[TB] FAIL run_init_pulses got %0d expected 1", pulse_cnt);
        end
        if (end_at != N_PAT + LAT + 2) begin
            errors++;
            $display("[TB] FAIL run_end_latency got %0d expected %0d", end_at, N_PAT + LAT + 2);
        end
        if (pass_fail !== want_pf || bist_end !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_verdict got end=%b pf=%b expected end=1 pf=%b", bist_end, pass_fail, want_pf);
        end
    endtask

    task automatic test_retrigger();
        int lfsr_cnt = 0;
        int end_at = -1;
        misr_sig = GOLDEN;
        bist_start = 1'b0;
        tick();
        for (int c = 1; c <= 14; c++) begin
            bist_start = (c == 3) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                $display("[TB] FAIL retrigger_outputs cycle %0d got %b expected %b", cyc, dut_out, exp_out());
            end
            if (lfsr_en) lfsr_cnt++;
            if (bist_end && end_at < 0) end_at = c - 1;
        end
        checks += 2;
        if (lfsr_cnt != N_PAT) begin
            errors++;
            $display("[TB] FAIL retrigger_lfsr_en_count got %0d expected %0d", lfsr_cnt, N_PAT);
        end
        if (end_at != N_PAT + LAT + 2) begin
            errors++;
            $display("[TB] FAIL retrigger_end_latency got %0d expected %0d", end_at, N_PAT + LAT + 2);
        end
    endtask

    task automatic test_restart();
        bist_start = 1'b0;
        misr_sig = GOLDEN;
        tick();
        bist_start = 1'b1;
        tick();
        checks++;
        if (bist_end !== 1'b0 || pass_fail !== 1'b0 || lfsr_load !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_drop got end=%b pf=%b load=%b expected end=0 pf=0 load=1",
                     bist_end, pass_fail, lfsr_load);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                $display("[TB] FAIL restart_outputs cycle %0d got %b expected %b", cyc, dut_out, exp_out());
            end
        end
        checks++;
        if (bist_end !== 1'b1 || pass_fail !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_verdict got end=%b pf=%b expected end=1 pf=1", bist_end, pass_fail);
        end
    endtask

    task automatic test_abort();
        misr_sig = GOLDEN;
        bist_start = 1'b0;
        tick();
        bist_start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (lfsr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_in_run got lfsr_en=%b expected 1", lfsr_en);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (dut_out !== 9'b0) begin
            errors++;
            $display("[TB] FAIL abort_cleared got %b expected %b", dut_out, 9'b0);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (dut_out !== 9'b0) begin
                errors++;
                $display("[TB] FAIL abort_idle cycle %0d got %b expected %b", cyc, dut_out, 9'b0);
            end
        end
        test_run(GOLDEN, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            misr_sig   = ($urandom_range(0, 1) == 1) ? GOLDEN : 16'($urandom);
            if ($urandom_range(0, 3) == 0) bist_start = ~bist_start;
            RST = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                $display("[TB] FAIL random_outputs cycle %0d got %b expected %b", cyc, dut_out, exp_out());
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run(GOLDEN, 1'b1);
        test_run(16'hA5C2, 1'b0);
        test_retrigger();
        test_restart();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
